// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor controller (master) and the
// multi-cycle memory target (slave).
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
);
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output Read, Write, addr, wdata,
    input  busy, done, rdata, err
  );

  modport slave (
    input  Read, Write, addr, wdata,
    output busy, done, rdata, err
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle word-addressed memory target. Captures one request, waits a
// fixed number of wait states, performs the access and pulses done (and err
// for illegal or out-of-range requests). All outputs come straight from flops.
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DEPTH       = 8192,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus_if
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;

  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Access operands: with zero wait states the access happens on the accept
  // edge itself, so it must use the live inputs rather than the captured copy.
  logic              w_op_rd;
  logic              w_op_wr;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;
  logic [IdxW-1:0]   w_idx;
  logic              w_enter_resp;
  logic              w_oor;
  logic              w_illegal;

  assign w_op_rd      = w_accept ? bus_if.Read  : r_rd;
  assign w_op_wr      = w_accept ? bus_if.Write : r_wr;
  assign w_op_addr    = w_accept ? bus_if.addr  : r_addr;
  assign w_op_wdata   = w_accept ? bus_if.wdata : r_wdata;
  assign w_idx        = w_op_addr[IdxW-1:0];
  assign w_enter_resp = (w_state_nxt == StResp);
  assign w_oor        = (32'(w_op_addr) >= DEPTH);
  assign w_illegal    = w_op_rd && w_op_wr;

  // Next-state logic; RESP also accepts so back-to-back requests issue every
  // WAIT_CYCLES+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle, StResp: begin
        w_state_nxt = StIdle;
        if (bus_if.Read || bus_if.Write) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CntLoad;
          w_state_nxt = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StResp;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != StIdle);
      r_done  <= w_enter_resp;
      r_err   <= w_enter_resp && (w_illegal || w_oor);
      if (w_enter_resp && w_op_rd && !w_op_wr) begin
        r_rdata <= w_oor ? '0 : r_mem[w_idx];
      end
    end
  end

  // Request capture at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_rd    <= bus_if.Read;
      r_wr    <= bus_if.Write;
      r_addr  <= bus_if.addr;
      r_wdata <= bus_if.wdata;
    end
  end

  // Storage array: not reset, written only by a legal in-range write.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_wr && !w_op_rd && !w_oor) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

  assign bus_if.busy  = r_busy;
  assign bus_if.done  = r_done;
  assign bus_if.err   = r_err;
  assign bus_if.rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: DUT a (DEPTH 4096, 2 wait states) and DUT b
// (DEPTH 8192, 0 wait states). A reference model pushes expected results to a
// scoreboard when a request is driven; they are popped on done.
module tb_mem_responder;

  logic clk;
  logic reset;

  mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if_a ();
  mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if_b ();

  mem_responder #(.DATA_W(16), .ADDR_W(13), .DEPTH(4096), .WAIT_CYCLES(2)) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .bus_if (if_a)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(13), .DEPTH(8192), .WAIT_CYCLES(0)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .bus_if (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] mem_m [int];
  logic [15:0] m_rdata [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [12:0] a, input logic [15:0] d);
    if (sel == 0) begin
      if_a.Read = rd; if_a.Write = wr; if_a.addr = a; if_a.wdata = d;
    end else begin
      if_b.Read = rd; if_b.Write = wr; if_b.addr = a; if_b.wdata = d;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? if_a.done : if_b.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if_a.busy : if_b.busy;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? if_a.err : if_b.err;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? if_a.rdata : if_b.rdata;
  endfunction

  // Reference behaviour of one transaction; result goes onto the scoreboard.
  task automatic model_push(input int sel, input logic rd, input logic wr,
                            input logic [12:0] a, input logic [15:0] d);
    exp_t e;
    int   key;
    int   depth;
    key   = sel * 65536 + int'(a);
    depth = (sel == 0) ? 4096 : 8192;
    e.err = 1'b0;
    if (rd && wr) begin
      e.err = 1'b1;
    end else if (int'(a) >= depth) begin
      e.err = 1'b1;
      if (rd) m_rdata[sel] = 16'h0000;
    end else if (rd) begin
      m_rdata[sel] = mem_m.exists(key) ? mem_m[key] : 16'h0000;
    end else begin
      mem_m[key] = d;
    end
    e.rdata = m_rdata[sel];
    sb_q.push_back(e);
  endtask

  // Called just after a falling edge; returns at the falling edge of the done
  // cycle so a following call issues back-to-back.
  task automatic run_req(input int sel, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [15:0] d, input bit poke);
    int   k;
    int   lat;
    exp_t e;
    lat = (sel == 0) ? 3 : 1;
    model_push(sel, rd, wr, a, d);
    drive(sel, rd, wr, a, d);
    @(posedge clk);
    @(negedge clk);
    k = 1;
    // Scramble inputs after accept; a poke is a write that must be ignored.
    if (poke) drive(sel, 1'b0, 1'b1, 13'h0006, 16'h1234);
    else      drive(sel, 1'b0, 1'b0, ~a, ~d);
    while (!get_done(sel) && k < 20) begin
      check_eq("busy_wait", 32'(get_busy(sel)), 32'd1);
      @(negedge clk);
      k++;
      if (poke && k == 2) drive(sel, 1'b0, 1'b0, ~a, ~d);
    end
    e = sb_q.pop_front();
    if (!get_done(sel)) begin
      check_eq("done_timeout", 32'd0, 32'd1);
      return;
    end
    check_eq("latency", k, lat);
    check_eq("busy_done", 32'(get_busy(sel)), 32'd1);
    check_eq("rdata", 32'(get_rdata(sel)), 32'(e.rdata));
    check_eq("err", 32'(get_err(sel)), 32'(e.err));
  endtask

  task automatic idle_check(input int sel);
    @(negedge clk);
    check_eq("idle_done", 32'(get_done(sel)), 32'd0);
    check_eq("idle_busy", 32'(get_busy(sel)), 32'd0);
    check_eq("idle_err", 32'(get_err(sel)), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy", 32'(if_a.busy), 32'd0);
    check_eq("rst_done", 32'(if_a.done), 32'd0);
    check_eq("rst_err", 32'(if_a.err), 32'd0);
    check_eq("rst_rdata", 32'(if_a.rdata), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 13'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 13'h0, 16'h0);
    m_rdata[0] = 16'h0000;
    m_rdata[1] = 16'h0000;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 reset = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write then back-to-back read.
    run_req(0, 1'b0, 1'b1, 13'h0005, 16'hBEEF, 1'b0);
    run_req(0, 1'b1, 1'b0, 13'h0005, 16'h0000, 1'b0);

    // Writes while busy are ignored.
    run_req(0, 1'b0, 1'b1, 13'h0006, 16'h1111, 1'b0);
    run_req(0, 1'b1, 1'b0, 13'h0005, 16'h0000, 1'b1);
    run_req(0, 1'b1, 1'b0, 13'h0006, 16'h0000, 1'b0);

    // Illegal Read+Write: err, rdata held, target untouched.
    run_req(0, 1'b0, 1'b1, 13'h0010, 16'h5555, 1'b0);
    run_req(0, 1'b1, 1'b1, 13'h0010, 16'hDEAD, 1'b0);
    run_req(0, 1'b1, 1'b0, 13'h0010, 16'h0000, 1'b0);

    // Out of range: boundary word, then addresses that would alias onto it.
    run_req(0, 1'b0, 1'b1, 13'h0FFF, 16'h0F0F, 1'b0);
    run_req(0, 1'b1, 1'b0, 13'h1000, 16'h0000, 1'b0);
    run_req(0, 1'b0, 1'b1, 13'h1FFF, 16'hDEAD, 1'b0);
    run_req(0, 1'b1, 1'b0, 13'h0FFF, 16'h0000, 1'b0);
    idle_check(0);

    // Reset during WAIT aborts a pending write.
    run_req(0, 1'b0, 1'b1, 13'h0002, 16'h1357, 1'b0);
    idle_check(0);
    drive(0, 1'b0, 1'b1, 13'h0002, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy", 32'(if_a.busy), 32'd1);
    drive(0, 1'b0, 1'b0, 13'h0, 16'h0);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    m_rdata[0] = 16'h0000;
    m_rdata[1] = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(if_a.done), 32'd0);
    end
    run_req(0, 1'b1, 1'b0, 13'h0002, 16'h0000, 1'b0);
    idle_check(0);

    // Zero wait states: done one cycle after accept.
    run_req(1, 1'b0, 1'b1, 13'h0002, 16'hAAAA, 1'b0);
    run_req(1, 1'b1, 1'b0, 13'h0002, 16'h0000, 1'b0);
    run_req(1, 1'b1, 1'b1, 13'h0002, 16'h7777, 1'b0);
    run_req(1, 1'b0, 1'b1, 13'h1FFF, 16'hC0DE, 1'b0);
    run_req(1, 1'b1, 1'b0, 13'h1FFF, 16'h0000, 1'b0);
    idle_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
